pop_serializer: RTL and testbench

POP_SERIALIZER -- requirements
Module: pop_serializer

---
 rtl/pop_serializer.sv | 120 ++++++++++++
 tb/tb_pop_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pop_serializer.sv
// Unpacks 32-byte FIFO words into OUT_BYTES-wide beats with per-lane keep.
// Registered beat outputs; a new word can be popped on the cycle its predecessor's last beat leaves.
module pop_serializer #(
   parameter int unsigned OUT_BYTES = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                   i_core_clk,
   input  logic                   i_rx_rst,
   input  logic                   PopEnable,
   output logic                   PopPermit,
   input  logic [4:0]             PopAmount,
   input  logic [255:0]           PopData,
   output logic [8*OUT_BYTES-1:0] o_data,
   output logic [OUT_BYTES-1:0]   o_keep,
   output logic                   o_valid,
   output logic                   o_last,
   input  logic                   i_ready,
   output logic [CNT_W-1:0]       o_word_cnt,
   output logic                   o_zero_err
);

   localparam int unsigned LaneW     = 8 * OUT_BYTES;
   localparam logic [5:0]  BeatBytes = 6'(OUT_BYTES);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q;
   logic [255:0]     word_q;
   logic [5:0]       rem_q;
   logic [LaneW-1:0] data_q;
   logic [OUT_BYTES-1:0] keep_q;
   logic             valid_q;
   logic             last_q;
   logic [CNT_W-1:0] cnt_q;
   logic             zero_err_q;

   logic             accept;
   logic             xfer;
   logic             start;
   logic             load;
   logic             drop;

   logic [255:0]     src_word;
   logic [5:0]       src_rem;
   logic [LaneW-1:0] beat_data;
   logic [OUT_BYTES-1:0] beat_keep;
   logic             beat_last;
   logic [255:0]     rest_word;
   logic [5:0]       rest_rem;

   assign accept    = valid_q & i_ready;
   assign PopPermit = ~i_rx_rst & ((state_q == StIdle) | (accept & last_q));
   assign xfer      = PopEnable & PopPermit;
   assign start     = xfer & (PopAmount != 5'd0);
   assign load      = start | (accept & ~last_q);
   assign drop      = accept & last_q & ~start;

   // Next beat comes from the incoming word on a transfer, otherwise from the held remainder.
   always_comb begin
      src_word  = xfer ? PopData : word_q;
      src_rem   = xfer ? {1'b0, PopAmount} : rem_q;
      beat_last = (src_rem <= BeatBytes);
      beat_keep = '0;
      beat_data = '0;
      for (int j = 0; j < int'(OUT_BYTES); j++) begin
         if (6'(j) < src_rem) begin
            beat_keep[j]        = 1'b1;
            beat_data[8*j +: 8] = src_word[8*j +: 8];
         end
      end
      rest_word = src_word >> LaneW;
      rest_rem  = beat_last ? 6'd0 : (src_rem - BeatBytes);
   end

   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         state_q    <= StIdle;
         word_q     <= '0;
         rem_q      <= '0;
         data_q     <= '0;
         keep_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
         zero_err_q <= 1'b0;
      end else begin
         if (xfer && (PopAmount == 5'd0)) begin
            zero_err_q <= 1'b1;
         end
         if (accept && last_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (load) begin
            state_q <= StShift;
            valid_q <= 1'b1;
            data_q  <= beat_data;
            keep_q  <= beat_keep;
            last_q  <= beat_last;
            word_q  <= rest_word;
            rem_q   <= rest_rem;
         end else if (drop) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            word_q  <= '0;
            rem_q   <= '0;
         end
      end
   end

   assign o_data     = data_q;
   assign o_keep     = keep_q;
   assign o_valid    = valid_q;
   assign o_last     = last_q;
   assign o_word_cnt = cnt_q;
   assign o_zero_err = zero_err_q;

endmodule

// File: tb/tb_pop_serializer.sv
// Directed bench for pop_serializer with 4-byte lanes and a 4-bit word counter.
module tb_pop_serializer;

   localparam int OB = 4;
   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           pop_en;
   logic           pop_permit;
   logic [4:0]     pop_amt;
   logic [255:0]   pop_data;
   logic [31:0]    o_data;
   logic [3:0]     o_keep;
   logic           o_valid;
   logic           o_last;
   logic           i_ready;
   logic [CW-1:0]  o_word_cnt;
   logic           o_zero_err;

   int nchk = 0;
   int npass = 0;
   int exp_cnt = 0;

   typedef struct {
      int         n;
      logic [7:0] base;
      int         beats;
      logic [3:0] last_keep;
   } vec_t;

   vec_t vecs[7];

   pop_serializer #(.OUT_BYTES(OB), .CNT_W(CW)) dut (
      .i_core_clk (clk),
      .i_rx_rst   (rst),
      .PopEnable  (pop_en),
      .PopPermit  (pop_permit),
      .PopAmount  (pop_amt),
      .PopData    (pop_data),
      .o_data     (o_data),
      .o_keep     (o_keep),
      .o_valid    (o_valid),
      .o_last     (o_last),
      .i_ready    (i_ready),
      .o_word_cnt (o_word_cnt),
      .o_zero_err (o_zero_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else npass++;
   endtask

   function automatic logic [255:0] mk(input logic [7:0] base);
      logic [255:0] w;
      for (int k = 0; k < 32; k++) w[8*k +: 8] = base + 8'(k);
      return w;
   endfunction

   // Expected beat: byte b*4+j in lane j, zero beyond the word length.
   function automatic logic [31:0] bd(input logic [7:0] base, input int n, input int b);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < OB; j++) begin
         if (b*OB + j < n) r[8*j +: 8] = base + 8'(b*OB + j);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input int n, input logic [7:0] base, input int exp_beats,
                            input logic [3:0] last_keep, input string tag);
      int  beats;
      bit  done;
      bit  is_last;
      pop_en   = 1'b1;
      pop_amt  = 5'(n);
      pop_data = mk(base);
      #1 check({tag, " permit_idle"}, pop_permit, 1);
      tick();
      pop_en = 1'b0;
      beats  = 0;
      done   = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (o_valid) begin
            is_last = (beats == exp_beats - 1);
            check($sformatf("%s data b%0d", tag, beats), o_data, bd(base, n, beats));
            check($sformatf("%s keep b%0d", tag, beats), o_keep, is_last ? last_keep : 4'hF);
            check($sformatf("%s last b%0d", tag, beats), o_last, is_last);
            check($sformatf("%s permit b%0d", tag, beats), pop_permit, is_last);
            if (is_last || o_last) done = 1;
            beats++;
         end
         tick();
      end
      check({tag, " beats"}, beats, exp_beats);
      check({tag, " idle_after"}, o_valid, 0);
      exp_cnt = (exp_cnt + 1) % 16;
      check({tag, " word_cnt"}, o_word_cnt, exp_cnt);
   endtask

   initial begin
      vecs[0] = '{n: 19, base: 8'h00, beats: 5, last_keep: 4'b0111};
      vecs[1] = '{n: 1,  base: 8'hA0, beats: 1, last_keep: 4'b0001};
      vecs[2] = '{n: 4,  base: 8'h40, beats: 1, last_keep: 4'b1111};
      vecs[3] = '{n: 8,  base: 8'h60, beats: 2, last_keep: 4'b1111};
      vecs[4] = '{n: 31, base: 8'h20, beats: 8, last_keep: 4'b0111};
      vecs[5] = '{n: 10, base: 8'h80, beats: 3, last_keep: 4'b0011};
      vecs[6] = '{n: 5,  base: 8'hF0, beats: 2, last_keep: 4'b0001};

      rst = 1'b1; pop_en = 1'b0; pop_amt = '0; pop_data = '0; i_ready = 1'b1;
      tick();
      tick();
      check("rst valid", o_valid, 0);
      check("rst data", o_data, 0);
      check("rst keep", o_keep, 0);
      check("rst last", o_last, 0);
      check("rst cnt", o_word_cnt, 0);
      check("rst zero_err", o_zero_err, 0);
      check("rst permit", pop_permit, 0);
      rst = 1'b0;
      #1 check("post_rst permit", pop_permit, 1);

      foreach (vecs[i]) send_word(vecs[i].n, vecs[i].base, vecs[i].beats, vecs[i].last_keep,
                                  $sformatf("vec%0d", i));

      // Back-to-back: N=31 then N=10 with no bubble between words.
      pop_en = 1'b1; pop_amt = 5'd31; pop_data = mk(8'h20);
      #1 check("b2b permit_idle", pop_permit, 1);
      tick();
      pop_amt = 5'd10; pop_data = mk(8'h80);
      for (int b = 0; b < 11; b++) begin
         if (b == 8) pop_en = 1'b0;
         check($sformatf("b2b valid b%0d", b), o_valid, 1);
         check($sformatf("b2b data b%0d", b), o_data,
               (b < 8) ? bd(8'h20, 31, b) : bd(8'h80, 10, b - 8));
         check($sformatf("b2b keep b%0d", b), o_keep,
               (b == 7) ? 4'b0111 : (b == 10) ? 4'b0011 : 4'hF);
         check($sformatf("b2b last b%0d", b), o_last, (b == 7) || (b == 10));
         check($sformatf("b2b permit b%0d", b), pop_permit, (b == 7) || (b == 10));
         tick();
      end
      check("b2b idle_after", o_valid, 0);
      exp_cnt = (exp_cnt + 2) % 16;
      check("b2b word_cnt", o_word_cnt, exp_cnt);

      // Stall: single-beat word held stable while i_ready is low.
      i_ready = 1'b0;
      pop_en = 1'b1; pop_amt = 5'd4; pop_data = mk(8'h40);
      #1 check("stall permit_idle", pop_permit, 1);
      tick();
      pop_en = 1'b0;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("stall valid s%0d", s), o_valid, 1);
         check($sformatf("stall data s%0d", s), o_data, 32'h43424140);
         check($sformatf("stall keep s%0d", s), o_keep, 4'hF);
         check($sformatf("stall last s%0d", s), o_last, 1);
         check($sformatf("stall permit s%0d", s), pop_permit, 0);
         tick();
      end
      i_ready = 1'b1;
      #1 check("stall permit_ready", pop_permit, 1);
      tick();
      check("stall idle_after", o_valid, 0);
      exp_cnt = (exp_cnt + 1) % 16;
      check("stall word_cnt", o_word_cnt, exp_cnt);

      // Zero-length word: sticky error, no beat, counter untouched.
      check("zero err_before", o_zero_err, 0);
      pop_en = 1'b1; pop_amt = 5'd0; pop_data = mk(8'h55);
      tick();
      pop_en = 1'b0;
      check("zero valid", o_valid, 0);
      check("zero err", o_zero_err, 1);
      check("zero cnt", o_word_cnt, exp_cnt);
      check("zero permit", pop_permit, 1);
      tick(); tick(); tick();
      check("zero err_sticky", o_zero_err, 1);
      check("zero valid_later", o_valid, 0);

      // Reset while beat 2 of an N=31 word is on the output.
      pop_en = 1'b1; pop_amt = 5'd31; pop_data = mk(8'h20);
      tick();
      pop_en = 1'b0;
      check("midrst last b0", o_last, 0);
      tick();
      check("midrst last b1", o_last, 0);
      tick();
      check("midrst data b2", o_data, bd(8'h20, 31, 2));
      check("midrst last b2", o_last, 0);
      rst = 1'b1;
      #1 check("midrst permit_in_rst", pop_permit, 0);
      tick();
      rst = 1'b0;
      check("midrst valid", o_valid, 0);
      check("midrst data", o_data, 0);
      check("midrst keep", o_keep, 0);
      check("midrst last", o_last, 0);
      check("midrst cnt", o_word_cnt, 0);
      check("midrst zero_err", o_zero_err, 0);
      exp_cnt = 0;
      send_word(4, 8'h40, 1, 4'hF, "after_rst");
      check("after_rst cnt_is_1", o_word_cnt, 1);

      // Counter wrap with a 4-bit counter: words 2..16 then word 17.
      for (int i = 0; i < 15; i++) send_word(1, 8'(i), 1, 4'b0001, $sformatf("wrap%0d", i));
      check("wrap cnt_after_16", o_word_cnt, 0);
      send_word(1, 8'h77, 1, 4'b0001, "wrap17");
      check("wrap cnt_after_17", o_word_cnt, 1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
